// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures high time, low time and period of a divided clock
// that is sampled as asynchronous data in the clk domain. Reports one result
// per completed divided-clock cycle and flags an input that stopped toggling.
module clk_div_monitor #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             duty_50,
    output logic             stuck
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // A level held for TIMEOUT samples is stuck; the check fires while the
    // counter still holds TIMEOUT-1 so the TIMEOUT-th sample triggers it.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic s1, s2, s3;
    logic rise, fall;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] low_time_q, low_time_d;
    logic [CNT_W:0]   period_q, period_d;
    logic             valid_q, valid_d;
    logic             duty_q, duty_d;
    logic             stuck_q, stuck_d;

    logic [CNT_W-1:0] high_inc, low_inc;
    logic [CNT_W:0]   period_new;
    logic [CNT_W+1:0] two_h, per_ext, duty_diff;
    logic             duty_new;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= div_clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    assign high_inc = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CNT_ONE;
    assign low_inc  = (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + CNT_ONE;

    // |2*high - period| <= 1, evaluated on the counts about to be loaded
    assign period_new = {1'b0, high_cnt_q} + {1'b0, low_cnt_q};
    assign two_h      = {1'b0, high_cnt_q, 1'b0};
    assign per_ext    = {1'b0, period_new};
    assign duty_diff  = (two_h >= per_ext) ? (two_h - per_ext) : (per_ext - two_h);
    assign duty_new   = (duty_diff <= (CNT_W+2)'(1));

    // Measurement FSM: next state, phase counters, timeout and result loading
    always_comb begin
        state_d     = state_q;
        high_cnt_d  = high_cnt_q;
        low_cnt_d   = low_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        high_time_d = high_time_q;
        low_time_d  = low_time_q;
        period_d    = period_q;
        duty_d      = duty_q;
        valid_d     = 1'b0;
        stuck_d     = stuck_q;

        if (rise) begin
            stuck_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = CNT_ONE;
                    low_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else if (fall) begin
                    hold_cnt_d = CNT_ONE;
                end else if (hold_cnt_q == TO_LAST) begin
                    stuck_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d   = ST_LOW;
                    low_cnt_d = CNT_ONE;
                end else if (high_cnt_q == TO_LAST) begin
                    stuck_d    = 1'b1;
                    state_d    = ST_IDLE;
                    high_cnt_d = '0;
                    low_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else begin
                    high_cnt_d = high_inc;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    high_time_d = high_cnt_q;
                    low_time_d  = low_cnt_q;
                    period_d    = period_new;
                    duty_d      = duty_new;
                    valid_d     = 1'b1;
                    state_d     = ST_HIGH;
                    high_cnt_d  = CNT_ONE;
                    low_cnt_d   = '0;
                end else if (low_cnt_q == TO_LAST) begin
                    stuck_d    = 1'b1;
                    state_d    = ST_IDLE;
                    high_cnt_d = '0;
                    low_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else begin
                    low_cnt_d = low_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            high_time_q <= '0;
            low_time_q  <= '0;
            period_q    <= '0;
            duty_q      <= 1'b0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            high_time_q <= high_time_d;
            low_time_q  <= low_time_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            valid_q     <= valid_d;
            stuck_q     <= stuck_d;
        end
    end

    assign high_time  = high_time_q;
    assign low_time   = low_time_q;
    assign period     = period_q;
    assign meas_valid = valid_q;
    assign duty_50    = duty_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: directed scenarios plus random
// phase lengths, compared each cycle against a run-length reference model.
module tb_clk_div_monitor;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned VW      = 3 * CNT_W + 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             div_clk_in = 1'b0;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             duty_50;
    logic             stuck;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_monitor #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .div_clk_in (div_clk_in),
        .high_time  (high_time),
        .low_time   (low_time),
        .period     (period),
        .meas_valid (meas_valid),
        .duty_50    (duty_50),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    // Reference model: the input seen two clocks late (synchronizer delay),
    // tracked as run lengths of constant level.
    logic pipe[$];
    logic m_prev;
    int   run_len, h_len;
    bit   armed, have_high;
    int   m_high, m_low, m_period;
    bit   m_valid, m_duty, m_stuck;

    function automatic void model_edge(input logic r, input logic x);
        logic y;
        m_valid = 1'b0;
        if (r) begin
            pipe = '{1'b0, 1'b0};
            m_prev = 1'b0; run_len = 0; h_len = 0; armed = 0; have_high = 0;
            m_high = 0; m_low = 0; m_period = 0; m_duty = 0; m_stuck = 0;
            return;
        end
        y = pipe.pop_front();
        pipe.push_back(x);
        if (y && !m_prev) begin
            if (armed && have_high) begin
                m_high   = h_len;
                m_low    = run_len;
                m_period = h_len + run_len;
                m_duty   = (h_len - run_len <= 1) && (run_len - h_len <= 1);
                m_valid  = 1'b1;
            end
            armed = 1; have_high = 0; m_stuck = 0; run_len = 1;
        end else if (!y && m_prev) begin
            if (armed) begin
                h_len = run_len;
                have_high = 1;
            end
            run_len = 1;
        end else begin
            run_len++;
            if (run_len >= int'(TIMEOUT)) begin
                m_stuck = 1; armed = 0; have_high = 0; run_len = 0;
            end
        end
        m_prev = y;
    endfunction

    function automatic logic [VW-1:0] got_vec();
        return {high_time, low_time, period, meas_valid, duty_50, stuck};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {CNT_W'(m_high), CNT_W'(m_low), (CNT_W+1)'(m_period), m_valid, m_duty, m_stuck};
    endfunction

    // Drive one clk cycle of stimulus, advance the model, settle past the edge
    task automatic step(input logic r, input logic x);
        @(negedge clk);
        rst = r;
        div_clk_in = x;
        @(posedge clk);
        model_edge(r, x);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, i[0]);
        n_checks++;
        if (got_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 0", got_vec());
        end
        // Only one input rise after release: no result may appear
        for (int i = 0; i < 7; i++) begin
            step(1'b0, (i == 1) || (i == 2));
            n_checks++;
            if (meas_valid !== 1'b0 || got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_div3();
        int cyc = 0, last = -1;
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 3; k++) begin
                step(1'b0, k == 0);
                n_checks++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL div3 cyc %0d: got %h expected %h", cyc, got_vec(), exp_vec());
                end
                if (meas_valid === 1'b1) begin
                    if (last >= 0) begin
                        n_checks++;
                        if (cyc - last != 3) begin
                            n_fail++;
                            $display("FAIL div3_gap: got %0d expected 3", cyc - last);
                        end
                    end
                    last = cyc;
                end
                cyc++;
            end
        end
        n_checks++;
        if ({high_time, low_time, period, duty_50} !== {8'd1, 8'd2, 9'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL div3_result: got h=%0d l=%0d p=%0d d=%0b expected 1 2 3 1",
                     high_time, low_time, period, duty_50);
        end
    endtask

    task automatic test_div4();
        int cyc = 0, pc = 0;
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b0, k == 0);
                n_checks++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL div4_13 cyc %0d: got %h expected %h", cyc, got_vec(), exp_vec());
                end
                cyc++;
            end
        end
        n_checks++;
        if ({high_time, low_time, period, duty_50} !== {8'd1, 8'd3, 9'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL div4_13_result: got h=%0d l=%0d p=%0d d=%0b expected 1 3 4 0",
                     high_time, low_time, period, duty_50);
        end
        // First pulse closes the last 1/3 cycle; the second is the first 2/2 cycle
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b0, k < 2);
                n_checks++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL div4_22 cyc %0d: got %h expected %h", cyc, got_vec(), exp_vec());
                end
                if (meas_valid === 1'b1) begin
                    pc++;
                    if (pc == 2) begin
                        n_checks++;
                        if (duty_50 !== 1'b1 || high_time !== 8'd2) begin
                            n_fail++;
                            $display("FAIL div4_22_first: got d=%0b h=%0d expected 1 2", duty_50, high_time);
                        end
                    end
                end
                cyc++;
            end
        end
    endtask

    task automatic test_stuck();
        int first_stuck = -1, clr = -1, meas = -1;
        for (int i = 0; i < 9; i++) step(1'b0, (i % 3) == 0);
        // Hold high: 16 samples captured at i=0..15, seen two clocks later
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stuck_hold cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
            // The pulse at i=2 closes the cycle before the hold
            if (i >= 3 && meas_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stuck_no_meas cyc %0d: got 1 expected 0", i);
            end
            if (stuck === 1'b1 && first_stuck < 0) first_stuck = i;
        end
        n_checks++;
        if (first_stuck != int'(TIMEOUT) + 1) begin
            n_fail++;
            $display("FAIL stuck_latency: got %0d expected %0d", first_stuck, TIMEOUT + 1);
        end
        // Resume divide-by-3: rise captured at j=2
        for (int j = 0; j < 12; j++) begin
            step(1'b0, (j % 3) == 2);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stuck_resume cyc %0d: got %h expected %h", j, got_vec(), exp_vec());
            end
            if (stuck === 1'b0 && clr < 0) clr = j;
            if (meas_valid === 1'b1 && meas < 0) meas = j;
        end
        n_checks++;
        if (clr != 4 || meas != 7) begin
            n_fail++;
            $display("FAIL stuck_recover: got clear=%0d meas=%0d expected 4 7", clr, meas);
        end
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        for (int i = 0; i < 19; i++) step(1'b0, (i % 7) < 3);
        step(1'b1, 1'b0);
        n_checks++;
        if (got_vec() !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_values: got %h expected 0", got_vec());
        end
        for (int i = 0; i < 23; i++) begin
            step(1'b0, (i >= 2) && (((i - 2) % 7) < 3));
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL mid_reset cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
            if (meas_valid === 1'b1 && seen == 0) begin
                seen = 1;
                n_checks++;
                if (high_time !== 8'd3 || low_time !== 8'd4) begin
                    n_fail++;
                    $display("FAIL mid_reset_first: got h=%0d l=%0d expected 3 4", high_time, low_time);
                end
            end
        end
    endtask

    task automatic test_long();
        int cyc = 0, last = -1;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 15; k++) begin
                step(1'b0, k < 10);
                n_checks++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL long cyc %0d: got %h expected %h", cyc, got_vec(), exp_vec());
                end
                if (meas_valid === 1'b1) begin
                    if (last >= 0 && cyc - last != 15) begin
                        n_fail++;
                        $display("FAIL long_gap: got %0d expected 15", cyc - last);
                    end
                    last = cyc;
                end
                cyc++;
            end
        end
        n_checks++;
        if ({high_time, low_time, period, duty_50} !== {8'd10, 8'd5, 9'd15, 1'b0}) begin
            n_fail++;
            $display("FAIL long_result: got h=%0d l=%0d p=%0d d=%0b expected 10 5 15 0",
                     high_time, low_time, period, duty_50);
        end
    endtask

    task automatic test_timeout_boundary();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        // Phases of TIMEOUT-1 are measured; a phase of TIMEOUT is stuck
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 30; i++) begin
                step(1'b0, i < 15);
                n_checks++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL boundary cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
                end
            end
        end
        for (int i = 0; i < 19; i++) step(1'b0, 1'b1);
        n_checks++;
        if ({high_time, low_time, period, duty_50, stuck} !== {8'd15, 8'd15, 9'd30, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL boundary_result: got h=%0d l=%0d p=%0d d=%0b s=%0b expected 15 15 30 1 1",
                     high_time, low_time, period, duty_50, stuck);
        end
    endtask

    task automatic test_random();
        int h, l;
        for (int n = 0; n < 30; n++) begin
            h = int'($urandom_range(1, TIMEOUT + 2));
            l = int'($urandom_range(1, TIMEOUT + 2));
            for (int k = 0; k < h + l; k++) begin
                step(1'b0, k < h);
                n_checks++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random h=%0d l=%0d k=%0d: got %h expected %h",
                             h, l, k, got_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_div3();
        test_div4();
        test_stuck();
        test_mid_reset();
        test_long();
        test_random();
        test_timeout_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
